control_direccion: RTL and testbench

- Consumer/decoder of the 3-bit button code from the input handler: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause, 6/7 unused.
- Filters the code for stability and turns each press into a single event.
- Maintains the snake heading with reversal protection and toggles the run/pause state.
- Generates the periodic movement pulse `paso` that the snake-body logic consumes; the new heading is applied on that pulse.

---
 rtl/control_direccion_if.sv | 25 ++
 rtl/control_direccion.sv | 133 +++++++++++++
 tb/tb_control_direccion.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_direccion_if.sv
// Button-code and game-control signals exchanged between the input handler,
// the direction controller and the snake-body logic.
interface control_direccion_if;
  logic [2:0] boton_pres;
  logic [2:0] direccion;
  logic       pausado;
  logic       paso;
  logic       evento;

  modport master (
    output boton_pres,
    input  direccion,
    input  pausado,
    input  paso,
    input  evento
  );

  modport slave (
    input  boton_pres,
    output direccion,
    output pausado,
    output paso,
    output evento
  );
endinterface

// File: rtl/control_direccion.sv
// Snake direction controller: debounces button codes into single events, keeps
// the heading with reversal protection, toggles pause and paces moves with paso.
module control_direccion #(
  parameter int HOLD_CYCLES = 16,
  parameter int TICK_DIV    = 1000
) (
  input logic                clk,
  input logic                rst_n,
  control_direccion_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] HOLD_V    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ONE_T     = TW'(1);

  typedef enum logic {JUEGO = 1'b0, PAUSA = 1'b1} estado_t;

  function automatic logic [2:0] opuesta(input logic [2:0] d);
    case (d)
      3'd1:    opuesta = 3'd2;
      3'd2:    opuesta = 3'd1;
      3'd3:    opuesta = 3'd4;
      3'd4:    opuesta = 3'd3;
      default: opuesta = 3'd0;
    endcase
  endfunction

  estado_t       r_estado;
  logic [2:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_dir;
  logic [2:0]    r_pend;
  logic          r_paso;
  logic          r_evento;

  logic          w_same;
  logic [CW-1:0] w_cnt_next;
  logic          w_accept;
  logic          w_tick;
  logic [2:0]    w_ref;
  logic          w_dir_ok;
  logic          w_pausa_ev;
  logic          w_evento;

  // Stability filter, tick detection and event classification.
  always_comb begin
    w_same     = (bus.boton_pres == r_prev);
    w_dir_ok   = 1'b0;
    w_pausa_ev = 1'b0;
    w_evento   = 1'b0;
    if (w_same) begin
      if (r_cnt == HOLD_V) begin
        w_cnt_next = HOLD_V;
      end else begin
        w_cnt_next = r_cnt + ONE_C;
      end
    end else begin
      w_cnt_next = ONE_C;
    end
    // A saturated run must not re-fire; with HOLD_CYCLES=1 a fresh code fires at once.
    w_accept = (w_cnt_next == HOLD_V) && !(w_same && (r_cnt == HOLD_V));
    w_tick   = (r_estado == JUEGO) && (r_tick == TICK_LAST);
    w_ref    = w_tick ? r_pend : r_dir;
    case (bus.boton_pres)
      3'd1, 3'd2, 3'd3, 3'd4: begin
        w_evento = w_accept;
        w_dir_ok = w_accept && (r_estado == JUEGO) && (bus.boton_pres != opuesta(w_ref));
      end
      3'd5: begin
        w_evento   = w_accept;
        w_pausa_ev = w_accept;
      end
      default: begin
        w_evento   = 1'b0;
        w_pausa_ev = 1'b0;
      end
    endcase
  end

  // Run/pause FSM with filter state, step timer and heading registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= JUEGO;
      r_prev   <= 3'd0;
      r_cnt    <= '0;
      r_tick   <= '0;
      r_dir    <= 3'd4;
      r_pend   <= 3'd4;
      r_paso   <= 1'b0;
      r_evento <= 1'b0;
    end else begin
      r_prev   <= bus.boton_pres;
      r_cnt    <= w_cnt_next;
      r_evento <= w_evento;
      if (w_dir_ok) begin
        r_pend <= bus.boton_pres;
      end
      case (r_estado)
        JUEGO: begin
          if (w_tick) begin
            r_tick <= '0;
            r_dir  <= r_pend;
            r_paso <= 1'b1;
          end else begin
            r_tick <= r_tick + ONE_T;
            r_paso <= 1'b0;
          end
          if (w_pausa_ev) begin
            r_estado <= PAUSA;
          end
        end
        PAUSA: begin
          r_paso <= 1'b0;
          if (w_pausa_ev) begin
            r_estado <= JUEGO;
          end
        end
        default: begin
          r_estado <= JUEGO;
          r_paso   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.direccion = r_dir;
  assign bus.pausado   = (r_estado == PAUSA);
  assign bus.paso      = r_paso;
  assign bus.evento    = r_evento;
endmodule

// File: tb/tb_control_direccion.sv
// Bench for control_direccion: directed vector table, hand-written corner
// sequences and random bursts, all compared against a behavioural model.
module tb_control_direccion;
  localparam int HOLD = 3;
  localparam int TICK = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_direccion_if bus();

  control_direccion #(.HOLD_CYCLES(HOLD), .TICK_DIV(TICK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: run length of identical samples and count of played edges.
  int         m_run    = 0;
  int         m_played = 0;
  logic [2:0] m_last   = 3'd0;
  logic [2:0] m_dir    = 3'd4;
  logic [2:0] m_pend   = 3'd4;
  logic       m_paused = 1'b0;
  logic       m_paso   = 1'b0;
  logic       m_ev     = 1'b0;

  typedef struct {
    logic [2:0] code;
    logic       rst;
    logic [2:0] dir;
    logic       pau;
    logic       paso;
    logic       ev;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    int x;
    x = int'(d);
    return 3'(((x - 1) ^ 1) + 1);
  endfunction

  task automatic model_step(input logic [2:0] code, input logic rv);
    logic       acc;
    logic       tick;
    logic [2:0] refd;
    if (!rv) begin
      m_run = 0; m_played = 0; m_last = 3'd0;
      m_dir = 3'd4; m_pend = 3'd4; m_paused = 1'b0; m_paso = 1'b0; m_ev = 1'b0;
      return;
    end
    if (code == m_last) m_run++;
    else begin
      m_run  = 1;
      m_last = code;
    end
    acc  = (m_run == HOLD);
    tick = !m_paused && (((m_played + 1) % TICK) == 0);
    refd = tick ? m_pend : m_dir;
    m_ev = acc && (code >= 3'd1) && (code <= 3'd5);
    if (!m_paused) begin
      m_played++;
      if (tick) m_dir = m_pend;
    end
    m_paso = tick;
    if (acc && !m_paused && code >= 3'd1 && code <= 3'd4 && code != reverse_of(refd))
      m_pend = code;
    if (acc && code == 3'd5) m_paused = !m_paused;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {dir,pau,paso,ev}=%b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.direccion, bus.pausado, bus.paso, bus.evento};
  endfunction

  task automatic cyc(input logic [2:0] code, input logic rv);
    bus.boton_pres = code;
    rst_n          = rv;
    @(posedge clk);
    model_step(code, rv);
    #1;
    check("model", outs(), {m_dir, m_paused, m_paso, m_ev});
  endtask

  task automatic press(input logic [2:0] code);
    for (int i = 0; i < HOLD; i++) cyc(code, 1'b1);
    cyc(3'd0, 1'b1);
  endtask

  task automatic wait_tick();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * TICK; i++) begin
      cyc(3'd0, 1'b1);
      if (bus.paso) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick at %0t: got no paso, required one within %0d cycles", $time, 3 * TICK);
    end
  endtask

  task automatic add(input logic [2:0] c, input logic r, input logic [2:0] d,
                     input logic pa, input logic ps, input logic e);
    vec_t v;
    v.code = c; v.rst = r; v.dir = d; v.pau = pa; v.paso = ps; v.ev = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic seen;
    bus.boton_pres = 3'd0;

    // Reset, idle ticking, held press, glitch.
    add(3'd0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(3'd0, 1'b1, 3'd4, 1'b0, (i == 8), 1'b0);
    add(3'd1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    add(3'd1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    add(3'd1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 12; i <= 15; i++) add(3'd1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    add(3'd1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    add(3'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    add(3'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    add(3'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    add(3'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 21; i <= 24; i++) add(3'd0, 1'b1, 3'd1, 1'b0, (i == 24), 1'b0);

    foreach (tbl[k]) begin
      cyc(tbl[k].code, tbl[k].rst);
      check($sformatf("vec%0d", k), outs(),
            {tbl[k].dir, tbl[k].pau, tbl[k].paso, tbl[k].ev});
    end

    // Turn to right, then a reversal (left) must be rejected.
    press(3'd4);
    wait_tick();
    check("dir_right", outs(), {3'd4, 1'b0, 1'b1, 1'b0});
    press(3'd3);
    wait_tick();
    check("reverse_rejected", outs(), {3'd4, 1'b0, 1'b1, 1'b0});

    // Down accepted on the tick edge is checked against pendiente=up.
    for (int i = 0; i < 3; i++) cyc(3'd1, 1'b1);
    cyc(3'd0, 1'b1);
    cyc(3'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(3'd2, 1'b1);
    check("tick_edge_event", outs(), {3'd1, 1'b0, 1'b1, 1'b1});
    wait_tick();
    check("tick_edge_rejected", outs(), {3'd1, 1'b0, 1'b1, 1'b0});

    // Last legal event between ticks wins.
    press(3'd4);
    wait_tick();
    press(3'd1);
    press(3'd2);
    check("last_wins", outs(), {3'd2, 1'b0, 1'b1, 1'b0});

    // Pause at tick counter 5, ignored direction while paused, resume.
    for (int i = 0; i < 3; i++) cyc(3'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(3'd5, 1'b1);
    check("paused", outs(), {3'd2, 1'b1, 1'b0, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(3'd0, 1'b1);
      seen |= bus.paso;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL no_paso_paused: got paso=1 required 0");
    end
    press(3'd3);
    for (int i = 0; i < 3; i++) cyc(3'd5, 1'b1);
    check("resumed", outs(), {3'd2, 1'b0, 1'b0, 1'b1});
    wait_tick();
    check("pause_ignored_dir", outs(), {3'd2, 1'b0, 1'b1, 1'b0});

    // Reset while paused with pendiente=down.
    press(3'd5);
    cyc(3'd0, 1'b0);
    check("mid_reset", outs(), {3'd4, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) cyc(3'd0, 1'b1);
    check("first_tick_after_reset", outs(), {3'd4, 1'b0, 1'b1, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(3'd6, 1'b1);
      seen |= bus.evento | bus.pausado;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL code6_ignored: got evento/pausado activity required none");
    end

    // Random bursts against the model.
    for (int b = 0; b < 400; b++) begin
      logic [2:0] c;
      int         len;
      logic       rv;
      c   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 6);
      rv  = ($urandom_range(0, 99) != 0);
      for (int j = 0; j < len; j++) cyc(c, (j == 0) ? rv : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
